// File: rtl/fp_pkg.sv
// Shared IEEE-754 single-precision types and constants for the FP arithmetic blocks.
package fp_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned EXP_MAX  = 255;
  localparam logic [31:0] FP_QNAN  = 32'h7FC0_0000;
  localparam logic [31:0] FP_INF   = 32'h7F80_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_MULT,
    ST_NORM_ROUND,
    ST_DONE
  } state_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier; denormals (exp==0) count as zero.
module fp_classify
  import fp_pkg::*;
(
  input  fp32_t x,
  output logic  is_zero,
  output logic  is_inf,
  output logic  is_nan
);

  // Sign does not affect the class.
  logic unused_sign;
  assign unused_sign = x.sign;

  always_comb begin
    is_zero = (x.exp == 8'd0);
    is_inf  = (x.exp == 8'(EXP_MAX)) && (x.frac == 23'd0);
    is_nan  = (x.exp == 8'(EXP_MAX)) && (x.frac != 23'd0);
  end

endmodule

// File: rtl/fp_multiplier_seq.sv
// Multi-cycle IEEE-754 single multiplier: shift-add mantissa product, RNE rounding, DAZ/FTZ,
// valid/ready handshake on operand and result sides.
module fp_multiplier_seq
  import fp_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned K     = BITS_PER_CYCLE;
  localparam int unsigned STEPS = 24 / K;

  if (K < 1 || K > 24 || (24 % K) != 0) begin : g_bad_bits_per_cycle
    $error("fp_multiplier_seq: BITS_PER_CYCLE must divide 24");
  end

  state_t             state;
  fp32_t              a_r;
  fp32_t              b_r;
  logic               sign_r;
  logic signed [9:0]  exp_r;
  logic [23:0]        ma;
  logic [47:0]        prod;
  logic [4:0]         cnt;

  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;

  fp_classify u_cls_a (.x(a_r), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan));
  fp_classify u_cls_b (.x(b_r), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan));

  // One shift-add step: prod holds {accumulator, unretired multiplier bits}.
  logic [23+K:0] pp;
  logic [23+K:0] step_sum;
  logic [47:0]   prod_step;

  assign pp       = {{K{1'b0}}, ma} * {24'd0, prod[K-1:0]};
  assign step_sum = {{K{1'b0}}, prod[47:24]} + pp;

  if (K == 24) begin : g_step_full
    assign prod_step = step_sum;
  end else begin : g_step_part
    assign prod_step = {step_sum, prod[23:K]};
  end

  // Normalize, round to nearest-even, then saturate to inf or flush to zero.
  logic               guard, sticky, rnd_up;
  logic [22:0]        mant;
  logic [24:0]        mant_rnd;
  logic [22:0]        frac_f;
  logic signed [9:0]  exp_n, exp_f;
  logic [31:0]        norm_result;

  always_comb begin
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_n  = exp_r + 10'sd1;
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
      exp_n  = exp_r;
    end
    rnd_up   = guard & (sticky | mant[0]);
    mant_rnd = {2'b01, mant} + 25'(rnd_up);
    exp_f    = mant_rnd[24] ? (exp_n + 10'sd1) : exp_n;
    frac_f   = mant_rnd[24] ? 23'd0 : mant_rnd[22:0];
    if (exp_f >= $signed(10'(EXP_MAX))) begin
      norm_result = FP_INF | {sign_r, 31'd0};
    end else if (exp_f <= 10'sd0) begin
      norm_result = {sign_r, 31'd0};
    end else begin
      norm_result = {sign_r, exp_f[7:0], frac_f};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      a_r       <= '0;
      b_r       <= '0;
      sign_r    <= 1'b0;
      exp_r     <= '0;
      ma        <= '0;
      prod      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= a;
            b_r      <= b;
            in_ready <= 1'b0;
            state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          sign_r <= a_r.sign ^ b_r.sign;
          state  <= ST_DONE;
          if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            result <= FP_QNAN;
          end else if (a_inf || b_inf) begin
            result <= FP_INF | {a_r.sign ^ b_r.sign, 31'd0};
          end else if (a_zero || b_zero) begin
            result <= {a_r.sign ^ b_r.sign, 31'd0};
          end else begin
            exp_r <= {2'b00, a_r.exp} + {2'b00, b_r.exp} - 10'(EXP_BIAS);
            ma    <= {1'b1, a_r.frac};
            prod  <= {24'd0, 1'b1, b_r.frac};
            cnt   <= '0;
            state <= ST_MULT;
          end
        end
        ST_MULT: begin
          prod <= prod_step;
          if (cnt == 5'(STEPS - 1)) begin
            state <= ST_NORM_ROUND;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        ST_NORM_ROUND: begin
          result <= norm_result;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          // out_valid rises one cycle after entry, then holds until consumed.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_multiplier_seq.sv
// Self-checking bench for fp_multiplier_seq: directed vector table, random ops vs an
// integer-arithmetic reference model, plus backpressure and mid-operation reset sequences.
module tb_fp_multiplier_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] result;
  logic        out_valid;
  logic        out_ready;

  int tests = 0;
  int fails = 0;

  fp_multiplier_seq #(.BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference: exact integer mantissa product, then round-to-nearest-even by remainder.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    int ex, ey, e, sh;
    logic s;
    logic xz, yz, xi, yi, xn, yn;
    longint unsigned p, q, rem, half;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    xz = (ex == 0); yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0); yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0); yn = (ey == 255) && (y[22:0] != 0);
    if (xn || yn) return 32'h7FC0_0000;
    if ((xi && yz) || (xz && yi)) return 32'h7FC0_0000;
    if (xi || yi) return {s, 8'hFF, 23'd0};
    if (xz || yz) return {s, 31'd0};
    p = (64'd8388608 + 64'(x[22:0])) * (64'd8388608 + 64'(y[22:0]));
    e = ex + ey - 127;
    sh = (p >= (64'd1 << 47)) ? 24 : 23;
    if (sh == 24) e++;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, 8'(e), q[22:0]};
  endfunction

  function automatic int ref_lat(input logic [31:0] x, input logic [31:0] y);
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0 || x[30:23] == 8'hFF || y[30:23] == 8'hFF)
      return 2;
    return 27;
  endfunction

  // Present operands to an idle DUT; returns result and cycles from accept to out_valid.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output int lat);
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    res = result;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] res, x, y;
    int lat, ov_seen;

    vecs[0]  = '{32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 27};
    vecs[1]  = '{32'hC0CC_CCCC, 32'hBF00_0000, 32'h404C_CCCC, 27};
    vecs[2]  = '{32'hC0CC_CCCC, 32'h3F00_0000, 32'hC04C_CCCC, 27};
    vecs[3]  = '{32'h3F80_0800, 32'h3F80_0800, 32'h3F80_1000, 27};
    vecs[4]  = '{32'h3F80_0800, 32'h3F80_1800, 32'h3F80_2002, 27};
    vecs[5]  = '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 27};
    vecs[6]  = '{32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 27};
    vecs[7]  = '{32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 27};
    vecs[8]  = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 2};
    vecs[9]  = '{32'h7FA0_0001, 32'h3F80_0000, 32'h7FC0_0000, 2};
    vecs[10] = '{32'h0000_0000, 32'hC040_0000, 32'h8000_0000, 2};
    vecs[11] = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 2};
    vecs[12] = '{32'h0000_0001, 32'hBF80_0000, 32'h8000_0000, 2};
    vecs[13] = '{32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE, 27};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].a, vecs[i].b, res, lat);
      check($sformatf("vec%0d result", i), res, vecs[i].exp);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d model", i), res, ref_mul(vecs[i].a, vecs[i].b));
      consume();
    end

    // Random operands against the reference model
    for (int i = 0; i < 60; i++) begin
      x = $urandom;
      y = $urandom;
      if (i % 3 != 0) begin
        x[30:23] = 8'($urandom_range(90, 164));
        y[30:23] = 8'($urandom_range(90, 164));
      end
      do_op(x, y, res, lat);
      check($sformatf("rand%0d %08h*%08h", i, x, y), res, ref_mul(x, y));
      check($sformatf("rand%0d latency", i), 32'(lat), 32'(ref_lat(x, y)));
      consume();
    end

    // Backpressure: result must hold and new operands be ignored while DONE is stalled
    out_ready = 1'b0;
    do_op(32'h3FC0_0000, 32'h4000_0000, res, lat);
    check("bp first result", res, 32'h4040_0000);
    for (int c = 0; c < 10; c++) begin
      a = $urandom; b = $urandom; in_valid = c[0];
      @(posedge clk); #1;
      check($sformatf("bp%0d out_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d result", c), result, 32'h4040_0000);
      check($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    consume();
    check("bp release out_valid", 32'(out_valid), 32'd0);
    check("bp release in_ready", 32'(in_ready), 32'd1);
    do_op(32'h4000_0000, 32'h4000_0000, res, lat);
    check("bp follow-up result", res, 32'h4080_0000);
    consume();

    // Reset at cycle 10 of a multiply
    a = 32'h3F80_0800; b = 32'h3F80_1800; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst in_ready", 32'(in_ready), 32'd1);
    check("midrst result", result, 32'h0);
    ov_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen++;
    end
    check("midrst spurious out_valid", 32'(ov_seen), 32'd0);
    do_op(32'h3F80_0800, 32'h3F80_1800, res, lat);
    check("midrst recovery result", res, 32'h3F80_2002);
    consume();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
